// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch-stage constants and state type
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - counts consecutive stall cycles, sets a sticky timeout flag
module stall_watchdog #(
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;

    always_comb begin
        cnt_d = '0;
        if (stall_i) begin
            cnt_d = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            // flag is raised on the edge the count reaches the limit and never cleared here
            if (cnt_d == MAX_CNT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/ifid_stall_ctrl.sv
// rtl/ifid_stall_ctrl.sv - PC and IF/ID register with stall, flush and imem wait handling (option: STALL_PERF_CNT_EN)
module ifid_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          MAX_STALL = 16,
    parameter int          CNT_W     = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    input  logic        InstrValid_i,
    input  logic [31:0] Instr_i,
    output logic [31:0] PC_o,
    output logic [31:0] IFIDInstr_o,
    output logic [31:0] IFIDPCPlus4_o,
    output logic        IFIDValid_o,
    output logic        Bubble_o,
    output logic        StallTimeout_o,
    output logic [31:0] StallCount_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus4;
    logic         bubble;

    assign bubble   = Stall_i & ~Flush_i;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (Flush_i) begin
            pc_d    = {BranchTarget_i[31:2], 2'b00};
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            // a fetch still outstanding in WAIT will return for the old PC and must be dropped
            state_d = (state_q == WAIT) ? DRAIN : RUN;
        end else if (!Stall_i) begin
            case (state_q)
                RUN, WAIT: begin
                    if (InstrValid_i) begin
                        pc_d    = pc_plus4;
                        instr_d = Instr_i;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        instr_d = NOP_INSTR;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                        state_d = WAIT;
                    end
                end
                DRAIN: begin
                    if (InstrValid_i) begin
                        instr_d = NOP_INSTR;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) u_stall_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stall_i   (bubble),
        .timeout_o (StallTimeout_o)
    );

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'h0;
        end else if (bubble && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCount_o = stall_cnt_q;
`else
    assign StallCount_o = 32'h0;
`endif

    assign PC_o          = pc_q;
    assign IFIDInstr_o   = instr_q;
    assign IFIDPCPlus4_o = pc4_q;
    assign IFIDValid_o   = valid_q;
    assign Bubble_o      = bubble;

endmodule

// File: tb/tb_ifid_stall_ctrl.sv
// tb/tb_ifid_stall_ctrl.sv - scoreboard bench for ifid_stall_ctrl against a behavioural fetch model
module tb_ifid_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] BranchTarget_i = 32'h0;
    logic        InstrValid_i = 1'b0;
    logic [31:0] Instr_i = 32'h0;
    logic [31:0] PC_o;
    logic [31:0] IFIDInstr_o;
    logic [31:0] IFIDPCPlus4_o;
    logic        IFIDValid_o;
    logic        Bubble_o;
    logic        StallTimeout_o;
    logic [31:0] StallCount_o;

    ifid_stall_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MAX_STALL (16),
        .CNT_W     (5)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Stall_i        (Stall_i),
        .Flush_i        (Flush_i),
        .BranchTarget_i (BranchTarget_i),
        .InstrValid_i   (InstrValid_i),
        .Instr_i        (Instr_i),
        .PC_o           (PC_o),
        .IFIDInstr_o    (IFIDInstr_o),
        .IFIDPCPlus4_o  (IFIDPCPlus4_o),
        .IFIDValid_o    (IFIDValid_o),
        .Bubble_o       (Bubble_o),
        .StallTimeout_o (StallTimeout_o),
        .StallCount_o   (StallCount_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        bubble;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        timeout;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // model: fetch outcome, not FSM encoding
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
    logic        m_valid = 1'b0, m_to = 1'b0;
    bit          m_fetch_missed = 0;  // the last fetch attempt saw no data yet
    bit          m_stale = 0;         // a response for a pre-redirect fetch is still due
    int          m_run = 0;           // consecutive bubble cycles
    longint      m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] t,
                        input bit v, input logic [31:0] ins);
        exp_t e;
        bit   bub;
        @(negedge clk_i);
        rst_i = r; Stall_i = s; Flush_i = f; BranchTarget_i = t; InstrValid_i = v; Instr_i = ins;
        bub = s && !f;
        e.bubble = bub;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_to = 0;
            m_fetch_missed = 0; m_stale = 0; m_run = 0; m_cnt = 0;
        end else begin
            if (f) begin
                m_pc = t & 32'hFFFF_FFFC;
                m_instr = 0; m_pc4 = 0; m_valid = 0;
                m_stale = m_fetch_missed && !m_stale;
                m_fetch_missed = 0;
            end else if (s) begin
                // everything frozen
            end else if (m_stale) begin
                if (v) begin
                    m_stale = 0;
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                end
            end else if (v) begin
                m_instr = ins;
                m_pc4 = (m_pc + 32'd4);
                m_valid = 1;
                m_pc = m_pc4;
                m_fetch_missed = 0;
            end else begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
                m_fetch_missed = 1;
            end
            if (bub) begin
                m_run = (m_run >= 16) ? 16 : m_run + 1;
                if (m_run == 16) m_to = 1;
            end else begin
                m_run = 0;
            end
`ifdef STALL_PERF_CNT_EN
            if (bub && m_cnt < 64'hFFFF_FFFF) m_cnt++;
`endif
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
        e.timeout = m_to; e.cnt = m_cnt[31:0];
        exp_q.push_back(e);
    endtask

    // monitor: combinational bubble mid-cycle, registered state just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                check("bubble", {31'h0, Bubble_o}, {31'h0, exp_q[0].bubble});
                @(posedge clk_i);
                #1;
                e = exp_q.pop_front();
                check("pc", PC_o, e.pc);
                check("ifid_instr", IFIDInstr_o, e.instr);
                check("ifid_pc4", IFIDPCPlus4_o, e.pc4);
                check("ifid_valid", {31'h0, IFIDValid_o}, {31'h0, e.valid});
                check("stall_timeout", {31'h0, StallTimeout_o}, {31'h0, e.timeout});
                check("stall_count", StallCount_o, e.cnt);
            end
        end
    end

    initial begin
        int guard;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // three fetches with a 2-cycle stall at PC=8
        step(0, 0, 0, 0, 1, 32'hA);
        step(0, 0, 0, 0, 1, 32'hB);
        step(0, 1, 0, 0, 1, 32'hC);
        step(0, 1, 0, 0, 1, 32'hC);
        step(0, 0, 0, 0, 1, 32'hC);
        // flush beats stall, low bits of target dropped
        step(0, 1, 1, 32'h103, 1, 32'hDEAD);
        step(0, 0, 0, 0, 1, 32'h1234);
        // imem miss at PC=4, redirect, stale data discarded, then fetch at 0x40
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h11);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h40, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hBAD);
        step(0, 0, 0, 0, 1, 32'h40_40);
        // 15 stalls stay below the limit, the 16th of a fresh run trips it
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 1, 32'h1);
        step(0, 0, 0, 0, 1, 32'h2);
        for (int i = 0; i < 18; i++) step(0, 1, 0, 0, $urandom_range(0, 1), 32'h3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, $urandom);
        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        step(0, 0, 0, 0, 1, 32'h77);
        step(0, 0, 0, 0, 1, 32'h78);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC | $urandom_range(0, 3) : $urandom,
                 ($urandom_range(0, 99) < 65),
                 $urandom);
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk_i);
            guard++;
        end
        #20;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
